cnn_window_gen: RTL and testbench
=================================

CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of one feature element.
REQ-002 Parameter KERNEL_ROW_SIZE, 3, kernel rows/cols; only 3 is supported.
REQ-003 Parameter INPUT_BRAM_ADDRESS_WIDTH, 12, line-buffer address width.
REQ-004 i_clock  in  1  sole clock; all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  one-cycle pulse starting one row pass; ignored unless idle.
REQ-007 i_base_address  in  INPUT_BRAM_ADDRESS_WIDTH  first column address, sampled with i_start.
REQ-008 i_row_width  in  INPUT_BRAM_ADDRESS_WIDTH  columns in the row, sampled with i_start.
REQ-009 o_renable  out  1  read enable to all three line-buffer port B instances.
REQ-010 o_raddress  out  INPUT_BRAM_ADDRESS_WIDTH  shared port-B read address.
REQ-011 i_bram_data  in  DATA_WIDTH x KERNEL_ROW_SIZE  row outputs from the line-buffer stage; index 0 is the top row.
REQ-012 o_window  out  DATA_WIDTH x 9  3x3 window; element r*3+c, where r is the row and c=0 is the oldest column.
REQ-013 o_window_valid / i_window_ready  out/in  1  valid/ready handshake; a transfer occurs when both are high.
REQ-014 o_busy  out  1  high while a pass is in progress.
REQ-015 o_done  out  1  one-cycle pulse when a pass completes.

Function
REQ-016 The line buffer has a fixed read latency of 1: data for an address presented with o_renable=1 before edge E appears on i_bram_data after E and is held while o_renable=0.
REQ-017 The state machine has states IDLE, READ, DRAIN and DONE.
- IDLE to READ on i_start when i_row_width>=3.
- IDLE to DONE on i_start when i_row_width<3; no reads and no windows are produced.
REQ-018 Define advance = !o_window_valid || i_window_ready; the datapath (column counter, read-valid flag, shift registers, window valid) updates only when advance=1.
REQ-019 READ state:
- o_renable = advance.
- o_raddress = base + col; col increments on advance.
- Leave for DRAIN after col = i_row_width-1 is issued.
REQ-020 A one-bit read-valid flag delays o_renable by one cycle; when the flag and advance are both set, each row's 3-deep shift register shifts in its i_bram_data element.
REQ-021 o_window_valid is set once 3 columns have been shifted in and remains asserted per shifted column thereafter; exactly i_row_width-2 windows are produced per pass (stride 1, no padding).
REQ-022 With i_window_ready held high, the first window is valid after the 4th rising edge after the i_start sampling edge, and subsequent windows are valid on consecutive cycles.
REQ-023 Backpressure: while o_window_valid=1 and i_window_ready=0, o_window, o_window_valid, o_raddress and all counters hold, o_renable=0, and no window is lost or duplicated.
REQ-024 DRAIN state goes to DONE when the last window is accepted; DONE asserts o_done for one cycle, then goes to IDLE.
REQ-025 o_busy=1 in READ and DRAIN; i_start is ignored while o_busy=1.
REQ-026 Address arithmetic is modulo 2^INPUT_BRAM_ADDRESS_WIDTH; base+col wraps without error.
REQ-027 If i_start and i_reset are high together, reset wins.

Reset
REQ-028 When i_reset=1 at an edge:
- state becomes IDLE;
- col, the read-valid flag and the shifted-column count clear;
- o_window_valid=0, o_done=0, o_busy=0, o_renable=0, o_raddress=0, o_window all zero.
REQ-029 Reset mid-pass aborts the pass immediately with no o_done; the next i_start after reset starts a clean pass.

Structure
REQ-030 The state enum and the KERNEL_ROW_SIZE/window-size constants reside in the shared package cnn_pkg.
REQ-031 The 3-deep per-row shift register is the sub-module cnn_row_shift, instantiated three times; the FSM and counters stay in the top module.

Verification
REQ-032 i_row_width=5, base=0, rows hold values 100+a/200+a/300+a, ready=1 -> 3 windows.
- First window after 4 edges: [100,101,102,200,201,202,300,301,302].
- o_done pulses one cycle after the third window.
REQ-033 i_row_width=6 with ready low for 3 cycles at the second window -> the second window holds stable, o_renable=0 during the stall, and 4 windows arrive in order with none dropped.
REQ-034 i_row_width=2 -> no o_renable, no windows, o_done one cycle after the start edge.
REQ-035 base=4094, width=4 (12-bit address) -> read addresses 4094, 4095, 0, 1 and 2 windows.
REQ-036 Reset asserted after the first window of a width-8 pass -> all outputs zero next cycle, no o_done; a following width-3 pass yields exactly 1 correct window.
REQ-037 i_start pulsed while o_busy=1 -> ignored; window count and addresses unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN window generator.
package cnn_pkg;

  localparam int unsigned CNN_KERNEL_ROW_SIZE = 3;
  localparam int unsigned CNN_WINDOW_SIZE     = CNN_KERNEL_ROW_SIZE * CNN_KERNEL_ROW_SIZE;

  // Pass-sequencer states, kept as plain constants for legacy tooling.
  typedef logic [1:0] cnn_state_t;
  localparam cnn_state_t StIdle  = 2'd0;
  localparam cnn_state_t StRead  = 2'd1;
  localparam cnn_state_t StDrain = 2'd2;
  localparam cnn_state_t StDone  = 2'd3;

endpackage

// File: rtl/cnn_window_gen_if.sv
// Control, line-buffer read port and window stream of the window generator.
interface cnn_window_gen_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);
  import cnn_pkg::*;

  logic                                             i_start;
  logic [ADDR_WIDTH-1:0]                            i_base_address;
  logic [ADDR_WIDTH-1:0]                            i_row_width;
  logic                                             o_renable;
  logic [ADDR_WIDTH-1:0]                            o_raddress;
  logic [CNN_KERNEL_ROW_SIZE-1:0][DATA_WIDTH-1:0]   i_bram_data;
  logic [CNN_WINDOW_SIZE-1:0][DATA_WIDTH-1:0]       o_window;
  logic                                             o_window_valid;
  logic                                             i_window_ready;
  logic                                             o_busy;
  logic                                             o_done;

  // Window generator side.
  modport slave (
    input  i_start, i_base_address, i_row_width, i_bram_data, i_window_ready,
    output o_renable, o_raddress, o_window, o_window_valid, o_busy, o_done
  );

  // Controller / line-buffer / consumer side.
  modport master (
    output i_start, i_base_address, i_row_width, i_bram_data, i_window_ready,
    input  o_renable, o_raddress, o_window, o_window_valid, o_busy, o_done
  );

endinterface

// File: rtl/cnn_row_shift.sv
// Three-deep column shift register for one kernel row; tap 0 holds the oldest column.
module cnn_row_shift
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                           i_clock,
  input  logic                                           i_reset,
  input  logic                                           i_shift,
  input  logic [DATA_WIDTH-1:0]                          i_data,
  output logic [CNN_KERNEL_ROW_SIZE-1:0][DATA_WIDTH-1:0] o_taps
);

  // New column enters at the top index, everything else moves one step older.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_taps <= '0;
    end else if (i_shift) begin
      o_taps <= {i_data, o_taps[CNN_KERNEL_ROW_SIZE-1:1]};
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Streams 3x3 windows of one row pass out of three line buffers (stride 1, no padding).
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH               = 32,
  parameter int unsigned KERNEL_ROW_SIZE          = 3,
  parameter int unsigned INPUT_BRAM_ADDRESS_WIDTH = 12
) (
  input  logic             i_clock,
  input  logic             i_reset,
  cnn_window_gen_if.slave  bus
);

  localparam int unsigned AW = INPUT_BRAM_ADDRESS_WIDTH;

  cnn_state_t        state_q, state_d;
  logic [AW-1:0]     base_q, width_q, col_q;
  logic              rvalid_q;
  logic [1:0]        shifted_q;
  logic              valid_q;
  logic              advance, renable, shift_en, last_col, start_ok;

  logic [KERNEL_ROW_SIZE-1:0][CNN_KERNEL_ROW_SIZE-1:0][DATA_WIDTH-1:0] taps;

  // A held, unaccepted window freezes the whole datapath.
  assign advance  = !valid_q || bus.i_window_ready;
  assign renable  = (state_q == StRead) && advance;
  assign shift_en = rvalid_q && advance;
  assign last_col = (col_q == width_q - AW'(1));
  assign start_ok = (state_q == StIdle) && bus.i_start;

  // Next-state logic of the pass sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d = (bus.i_row_width >= AW'(3)) ? StRead : StDone;
        end
      end
      StRead: begin
        if (advance && last_col) state_d = StDrain;
      end
      // The last window is the one accepted once no read is still in flight.
      StDrain: begin
        if (valid_q && bus.i_window_ready && !rvalid_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, pass parameters, column counter and window-valid tracking.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= StIdle;
      base_q    <= '0;
      width_q   <= '0;
      col_q     <= '0;
      rvalid_q  <= 1'b0;
      shifted_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q    <= bus.i_base_address;
        width_q   <= bus.i_row_width;
        col_q     <= '0;
        rvalid_q  <= 1'b0;
        shifted_q <= '0;
        valid_q   <= 1'b0;
      end else if (advance) begin
        if (renable) col_q <= col_q + AW'(1);
        rvalid_q <= renable;
        if (rvalid_q && shifted_q != 2'd3) shifted_q <= shifted_q + 2'd1;
        // Third and later shifted columns each complete a window.
        valid_q <= rvalid_q && (shifted_q >= 2'd2);
      end
    end
  end

  for (genvar r = 0; r < KERNEL_ROW_SIZE; r++) begin : g_row
    cnn_row_shift #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_row_shift (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_shift (shift_en),
      .i_data  (bus.i_bram_data[r]),
      .o_taps  (taps[r])
    );
  end

  // Flatten row taps into the row-major window.
  always_comb begin
    bus.o_window = '0;
    for (int r = 0; r < KERNEL_ROW_SIZE; r++) begin
      for (int c = 0; c < CNN_KERNEL_ROW_SIZE; c++) begin
        bus.o_window[r*CNN_KERNEL_ROW_SIZE + c] = taps[r][c];
      end
    end
  end

  assign bus.o_renable      = renable;
  assign bus.o_raddress     = base_q + col_q;
  assign bus.o_window_valid = valid_q;
  assign bus.o_busy         = (state_q == StRead) || (state_q == StDrain);
  assign bus.o_done         = (state_q == StDone);

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen with a scoreboard of expected windows and read addresses.
module tb_cnn_window_gen;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int WW = 9 * DW;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int tests    = 0;
  int fails    = 0;
  int win_cnt  = 0;
  int done_cnt = 0;

  logic [WW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];

  cnn_window_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cnn_window_gen #(
    .DATA_WIDTH               (DW),
    .KERNEL_ROW_SIZE          (3),
    .INPUT_BRAM_ADDRESS_WIDTH (AW)
  ) dut (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_window(input int base, input int k);
    logic [8:0][DW-1:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r*3+c] = DW'((r + 1) * 100 + ((base + k + c) % 4096));
    return w;
  endfunction

  // Line buffer model: one-cycle read latency, output held when not reading.
  always @(posedge clock) begin
    if (bus.o_renable)
      for (int r = 0; r < 3; r++)
        bus.i_bram_data[r] <= DW'((r + 1) * 100) + DW'(bus.o_raddress);
  end

  // Scoreboard: every transfer and every issued read is compared in order.
  always @(negedge clock) begin
    if (bus.o_window_valid && bus.i_window_ready) begin
      win_cnt++;
      check("window_pending", WW'(exp_q.size() > 0), WW'(1));
      if (exp_q.size() > 0) check("window", bus.o_window, exp_q.pop_front());
    end
    if (bus.o_renable) begin
      check("read_pending", WW'(addr_q.size() > 0), WW'(1));
      if (addr_q.size() > 0) check("raddress", WW'(bus.o_raddress), WW'(addr_q.pop_front()));
    end
    if (bus.o_done) done_cnt++;
  end

  // Called just after a rising edge; i_start is sampled on the next edge.
  task automatic start_pass(input int base, input int width);
    if (width >= 3) begin
      for (int k = 0; k < width - 2; k++) exp_q.push_back(exp_window(base, k));
      for (int c = 0; c < width; c++) addr_q.push_back(AW'((base + c) % 4096));
    end
    bus.i_start        = 1'b1;
    bus.i_base_address = AW'(base);
    bus.i_row_width    = AW'(width);
    @(posedge clock); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clock);
      if (bus.o_done) seen = 1'b1;
    end
    check(tag, WW'(seen), WW'(1));
    @(posedge clock); #1;
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_win_left"}, WW'(exp_q.size()), WW'(0));
    check({tag, "_addr_left"}, WW'(addr_q.size()), WW'(0));
  endtask

  initial begin
    int w0;
    int d0;
    bus.i_start        = 1'b0;
    bus.i_base_address = '0;
    bus.i_row_width    = '0;
    bus.i_window_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_valid", WW'(bus.o_window_valid), WW'(0));
    check("rst_done", WW'(bus.o_done), WW'(0));
    check("rst_busy", WW'(bus.o_busy), WW'(0));
    check("rst_renable", WW'(bus.o_renable), WW'(0));
    check("rst_raddress", WW'(bus.o_raddress), WW'(0));
    check("rst_window", bus.o_window, WW'(0));
    @(posedge clock); #1;

    // Width 5, base 0: latency, window contents, done timing
    w0 = win_cnt;
    start_pass(0, 5);
    repeat (4) @(negedge clock);
    check("t1_valid_before_4th_edge", WW'(bus.o_window_valid), WW'(0));
    @(negedge clock);
    check("t1_valid_after_4th_edge", WW'(bus.o_window_valid), WW'(1));
    check("t1_first_window", bus.o_window, exp_window(0, 0));
    check("t1_busy", WW'(bus.o_busy), WW'(1));
    repeat (2) @(negedge clock);
    check("t1_done_early", WW'(bus.o_done), WW'(0));
    @(negedge clock);
    check("t1_done", WW'(bus.o_done), WW'(1));
    check("t1_busy_in_done", WW'(bus.o_busy), WW'(0));
    check("t1_win_count", WW'(win_cnt - w0), WW'(3));
    @(negedge clock);
    check("t1_done_one_cycle", WW'(bus.o_done), WW'(0));
    check_queues("t1");
    @(posedge clock); #1;

    // Width 6, base 10: stall three cycles on the second window
    w0 = win_cnt;
    start_pass(10, 6);
    repeat (5) @(posedge clock);
    #1 bus.i_window_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      check("t2_stall_valid", WW'(bus.o_window_valid), WW'(1));
      check("t2_stall_window", bus.o_window, exp_window(10, 1));
      check("t2_stall_renable", WW'(bus.o_renable), WW'(0));
      check("t2_stall_raddress", WW'(bus.o_raddress), WW'(15));
    end
    @(posedge clock);
    #1 bus.i_window_ready = 1'b1;
    wait_done("t2_done_seen");
    check("t2_win_count", WW'(win_cnt - w0), WW'(4));
    check_queues("t2");

    // Width 2: no reads, no windows, immediate done
    w0 = win_cnt;
    start_pass(0, 2);
    @(negedge clock);
    check("t3_done", WW'(bus.o_done), WW'(1));
    check("t3_busy", WW'(bus.o_busy), WW'(0));
    @(negedge clock);
    check("t3_done_one_cycle", WW'(bus.o_done), WW'(0));
    check("t3_win_count", WW'(win_cnt - w0), WW'(0));
    @(posedge clock); #1;

    // Address wrap: base 4094, width 4
    w0 = win_cnt;
    start_pass(4094, 4);
    wait_done("t4_done_seen");
    check("t4_win_count", WW'(win_cnt - w0), WW'(2));
    check_queues("t4");

    // i_start while busy is ignored
    w0 = win_cnt;
    start_pass(20, 5);
    repeat (2) @(posedge clock);
    #1;
    bus.i_start        = 1'b1;
    bus.i_base_address = AW'(100);
    bus.i_row_width    = AW'(7);
    @(negedge clock);
    check("t5_busy", WW'(bus.o_busy), WW'(1));
    @(posedge clock);
    #1 bus.i_start = 1'b0;
    wait_done("t5_done_seen");
    check("t5_win_count", WW'(win_cnt - w0), WW'(3));
    check_queues("t5");

    // Reset mid-pass after the first window, then a clean width-3 pass
    d0 = done_cnt;
    start_pass(0, 8);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t6_valid", WW'(bus.o_window_valid), WW'(0));
    check("t6_busy", WW'(bus.o_busy), WW'(0));
    check("t6_renable", WW'(bus.o_renable), WW'(0));
    check("t6_raddress", WW'(bus.o_raddress), WW'(0));
    check("t6_window", bus.o_window, WW'(0));
    exp_q.delete();
    addr_q.delete();
    repeat (4) @(negedge clock);
    check("t6_no_done", WW'(done_cnt - d0), WW'(0));
    @(posedge clock); #1;
    w0 = win_cnt;
    start_pass(50, 3);
    wait_done("t6_done_seen");
    check("t6_win_count", WW'(win_cnt - w0), WW'(1));
    check_queues("t6");

    // Reset and start together: reset wins
    reset              = 1'b1;
    bus.i_start        = 1'b1;
    bus.i_base_address = AW'(0);
    bus.i_row_width    = AW'(5);
    @(posedge clock);
    #1;
    reset       = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clock);
    check("t7_busy", WW'(bus.o_busy), WW'(0));
    check("t7_done", WW'(bus.o_done), WW'(0));
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
